processing_element: RTL and testbench

- Single output-stationary MAC cell of the NxN systolic array.
- Operand A enters from the left; operand B (weight) enters from the top. Each is registered and forwarded right/down.
- Accumulates signed products into a stationary 64-bit accumulator, with packed-SIMD precision modes.
- In drain mode, the vertical bus becomes an accumulator shift chain that unloads results out of the bottom edge.

---
 rtl/processing_element.sv | 106 ++++++++++
 tb/tb_processing_element.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/processing_element.sv
// Output-stationary MAC cell for an NxN systolic array: operands flow right/down,
// products accumulate in place, and the vertical bus doubles as a drain shift chain.
package processing_element_pkg;
    typedef enum logic [1:0] {
        PREC_INT4  = 2'b00,
        PREC_INT8  = 2'b01,
        PREC_INT16 = 2'b10,
        PREC_RSVD  = 2'b11
    } precision_mode_t;
endpackage

module processing_element
    import processing_element_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       input_from_left,
    output logic [DATA_WIDTH-1:0]       input_to_right,
    input  logic                        last_in,
    output logic                        last_out,
    input  logic signed [ACC_WIDTH-1:0] data_from_top,
    output logic signed [ACC_WIDTH-1:0] data_to_bottom,
    input  precision_mode_t             precision_mode,
    input  logic                        compute_enable,
    input  logic                        drain_enable,
    input  logic                        acc_clear,
    output logic signed [ACC_WIDTH-1:0] acc_out
);

    localparam int N8 = DATA_WIDTH / 8;
    localparam int N4 = DATA_WIDTH / 4;

    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic        [DATA_WIDTH-1:0] a_reg;
    logic signed [ACC_WIDTH-1:0] w_reg;
    logic                        last_reg;

    logic [DATA_WIDTH-1:0] w_op;
    assign w_op = data_from_top[DATA_WIDTH-1:0];

    // Lane products, each wide enough to hold its full signed result.
    logic signed [2*DATA_WIDTH-1:0] p16;
    logic signed [15:0]             p8 [N8];
    logic signed [7:0]              p4 [N4];

    assign p16 = $signed(input_from_left) * $signed(w_op);

    generate
        for (genvar gi = 0; gi < N8; gi++) begin : g_int8
            assign p8[gi] = $signed(input_from_left[8*gi +: 8]) * $signed(w_op[8*gi +: 8]);
        end
        for (genvar gi = 0; gi < N4; gi++) begin : g_int4
            assign p4[gi] = $signed(input_from_left[4*gi +: 4]) * $signed(w_op[4*gi +: 4]);
        end
    endgenerate

    logic signed [ACC_WIDTH-1:0] prod_next;

    always_comb begin
        prod_next = '0;
        case (precision_mode)
            PREC_INT4: begin
                for (int k = 0; k < N4; k++)
                    prod_next = prod_next + {{(ACC_WIDTH-8){p4[k][7]}}, p4[k]};
            end
            PREC_INT8: begin
                for (int k = 0; k < N8; k++)
                    prod_next = prod_next + {{(ACC_WIDTH-16){p8[k][15]}}, p8[k]};
            end
            default: prod_next = {{(ACC_WIDTH-2*DATA_WIDTH){p16[2*DATA_WIDTH-1]}}, p16};
        endcase
    end

    // Clear beats drain beats compute; the marker advances every cycle unless cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            a_reg    <= '0;
            w_reg    <= '0;
            last_reg <= 1'b0;
        end else if (acc_clear) begin
            acc_reg  <= '0;
            a_reg    <= '0;
            w_reg    <= '0;
            last_reg <= 1'b0;
        end else begin
            last_reg <= last_in;
            if (drain_enable) begin
                acc_reg <= data_from_top;
            end else if (compute_enable) begin
                acc_reg <= acc_reg + prod_next;
                a_reg   <= input_from_left;
                w_reg   <= data_from_top;
            end
        end
    end

    assign acc_out        = acc_reg;
    assign input_to_right = a_reg;
    assign last_out       = last_reg;
    assign data_to_bottom = drain_enable ? acc_reg : w_reg;

endmodule

// File: tb/tb_processing_element.sv
// Self-checking bench for processing_element: vector table through a scoreboard queue,
// plus hand sequences for reset, drain pre-edge output and asynchronous reset abort.
module tb_processing_element;
    import processing_element_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [15:0]         input_from_left;
    logic [15:0]         input_to_right;
    logic                last_in;
    logic                last_out;
    logic signed [63:0]  data_from_top;
    logic signed [63:0]  data_to_bottom;
    precision_mode_t     precision_mode;
    logic                compute_enable;
    logic                drain_enable;
    logic                acc_clear;
    logic signed [63:0]  acc_out;

    int n_cmp  = 0;
    int n_fail = 0;

    processing_element #(.DATA_WIDTH(16), .ACC_WIDTH(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .input_from_left (input_from_left),
        .input_to_right  (input_to_right),
        .last_in         (last_in),
        .last_out        (last_out),
        .data_from_top   (data_from_top),
        .data_to_bottom  (data_to_bottom),
        .precision_mode  (precision_mode),
        .compute_enable  (compute_enable),
        .drain_enable    (drain_enable),
        .acc_clear       (acc_clear),
        .acc_out         (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clear;
        logic        drain;
        logic        comp;
        logic        last;
        logic [1:0]  mode;
        logic [15:0] a;
        logic [63:0] top;
        logic [63:0] e_acc;
        logic [15:0] e_itr;
        logic [63:0] e_dtb;
        logic        e_last;
    } vec_t;

    typedef struct {
        int          idx;
        logic [63:0] acc;
        logic [15:0] itr;
        logic [63:0] dtb;
        logic        last;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        acc_clear       = 1'b0;
        drain_enable    = 1'b0;
        compute_enable  = 1'b0;
        last_in         = 1'b0;
        precision_mode  = PREC_INT16;
        input_from_left = '0;
        data_from_top   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".acc_out"},        acc_out,               64'd0);
        check({tag, ".input_to_right"}, {48'd0, input_to_right}, 64'd0);
        check({tag, ".data_to_bottom"}, data_to_bottom,        64'd0);
        check({tag, ".last_out"},       {63'd0, last_out},     64'd0);
    endtask

    task automatic apply_vec(input int i);
        exp_t e;
        @(negedge clk);
        acc_clear       = vecs[i].clear;
        drain_enable    = vecs[i].drain;
        compute_enable  = vecs[i].comp;
        last_in         = vecs[i].last;
        precision_mode  = precision_mode_t'(vecs[i].mode);
        input_from_left = vecs[i].a;
        data_from_top   = vecs[i].top;
        e.idx  = i;
        e.acc  = vecs[i].e_acc;
        e.itr  = vecs[i].e_itr;
        e.dtb  = vecs[i].e_dtb;
        e.last = vecs[i].e_last;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("vec %0d: acc_out=%h itr=%h dtb=%h last=%b", e.idx, acc_out, input_to_right,
                 data_to_bottom, last_out);
        check($sformatf("vec%0d.acc_out", e.idx), acc_out, e.acc);
        check($sformatf("vec%0d.input_to_right", e.idx), {48'd0, input_to_right}, {48'd0, e.itr});
        check($sformatf("vec%0d.data_to_bottom", e.idx), data_to_bottom, e.dtb);
        check($sformatf("vec%0d.last_out", e.idx), {63'd0, last_out}, {63'd0, e.last});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           clr drn cmp lst mode   a         top                     e_acc                   e_itr     e_dtb                  e_last
        vecs[0]  = '{0, 0, 1, 0, 2'b10, 16'h0003, 64'd5,                 64'd15,                 16'h0003, 64'd5,                 0};
        vecs[1]  = '{0, 0, 1, 0, 2'b10, 16'hFFFE, 64'd7,                 64'd1,                  16'hFFFE, 64'd7,                 0};
        vecs[2]  = '{1, 0, 0, 0, 2'b10, 16'h0000, 64'd0,                 64'd0,                  16'h0000, 64'd0,                 0};
        vecs[3]  = '{0, 0, 1, 0, 2'b01, 16'h02FF, 64'h0304,              64'd2,                  16'h02FF, 64'h0304,              0};
        vecs[4]  = '{1, 0, 0, 0, 2'b10, 16'h0000, 64'd0,                 64'd0,                  16'h0000, 64'd0,                 0};
        vecs[5]  = '{0, 0, 1, 0, 2'b00, 16'h1F27, 64'h2311,              64'd8,                  16'h1F27, 64'h2311,              0};
        vecs[6]  = '{0, 0, 0, 1, 2'b10, 16'h1234, 64'd99,                64'd8,                  16'h1F27, 64'h2311,              1};
        vecs[7]  = '{0, 1, 1, 0, 2'b10, 16'h0005, 64'd100,               64'd100,                16'h1F27, 64'd100,               0};
        vecs[8]  = '{0, 1, 0, 0, 2'b10, 16'h0000, 64'd42,                64'd42,                 16'h1F27, 64'd42,                0};
        vecs[9]  = '{1, 0, 1, 1, 2'b10, 16'h0005, 64'd5,                 64'd0,                  16'h0000, 64'd0,                 0};
        vecs[10] = '{0, 1, 0, 0, 2'b10, 16'h0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 16'h0000, 64'h7FFF_FFFF_FFFF_FFFF, 0};
        vecs[11] = '{0, 0, 1, 0, 2'b10, 16'h0001, 64'd1,                 64'h8000_0000_0000_0000, 16'h0001, 64'd1,                 0};
        vecs[12] = '{0, 0, 1, 0, 2'b11, 16'hFFFF, 64'd3,                 64'h7FFF_FFFF_FFFF_FFFD, 16'hFFFF, 64'd3,                 0};
        vecs[13] = '{0, 0, 1, 0, 2'b01, 16'h8080, 64'h8080,              64'h8000_0000_0000_7FFD, 16'h8080, 64'h8080,              0};
        vecs[14] = '{0, 0, 1, 0, 2'b00, 16'h8888, 64'h8888,              64'h8000_0000_0000_80FD, 16'h8888, 64'h8888,              0};
        vecs[15] = '{0, 0, 1, 0, 2'b10, 16'h8000, 64'h8000,              64'h8000_0000_4000_80FD, 16'h8000, 64'h8000,              0};

        // Reset, then five idle cycles with everything still zero.
        drive_idle();
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        check_all_zero("idle5");

        for (int i = 0; i < 16; i++) apply_vec(i);

        // data_to_bottom shows the old accumulator as soon as drain rises, before the edge.
        @(negedge clk);
        drive_idle();
        drain_enable  = 1'b1;
        data_from_top = 64'd100;
        @(posedge clk);
        #1;
        @(negedge clk);
        data_from_top = 64'd42;
        #1;
        $display("drain pre-edge: data_to_bottom=%0d", data_to_bottom);
        check("drain.pre_edge_dtb", data_to_bottom, 64'd100);
        @(posedge clk);
        #1;
        $display("drain post-edge: acc_out=%0d", acc_out);
        check("drain.post_edge_acc", acc_out, 64'd42);

        // Single-cycle marker pulse with no enables.
        @(negedge clk);
        drive_idle();
        last_in = 1'b1;
        @(posedge clk);
        #1;
        check("marker.rise", {63'd0, last_out}, 64'd1);
        @(negedge clk);
        last_in = 1'b0;
        @(posedge clk);
        #1;
        $display("marker: last_out=%b after pulse end", last_out);
        check("marker.fall", {63'd0, last_out}, 64'd0);

        // Asynchronous reset mid-operation clears state without waiting for an edge.
        @(negedge clk);
        compute_enable  = 1'b1;
        input_from_left = 16'h0004;
        data_from_top   = 64'd9;
        @(posedge clk);
        #1;
        check("abort.pre_acc", acc_out, 64'd78);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: acc_out=%h itr=%h", acc_out, input_to_right);
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
